// File: rtl/ddfs_adsr_if.sv
// ddfs_adsr_if: control/status bundle between the register file and one
// ADSR envelope sequencer (steps, sustain setup, start/stop, env readback).
interface ddfs_adsr_if #(
  parameter int SUS_W = 32
);
  logic               start;
  logic               stop;
  logic [31:0]        attack_step;
  logic [31:0]        decay_step;
  logic [15:0]        sustain_level;
  logic [SUS_W-1:0]   sustain_time;
  logic [31:0]        release_step;
  logic signed [15:0] env;
  logic               idle;
  logic [2:0]         state_o;

  modport master (
    output start, stop, attack_step, decay_step, sustain_level,
           sustain_time, release_step,
    input  env, idle, state_o
  );

  modport slave (
    input  start, stop, attack_step, decay_step, sustain_level,
           sustain_time, release_step,
    output env, idle, state_o
  );
endinterface

// File: rtl/ddfs_adsr.sv
// ddfs_adsr: attack/decay/sustain/release envelope generator feeding the
// DDFS env input (Q2.14, 0x4000 = 1.0). Optional macro DDFS_ADSR_BYPASS_EN
// adds a bypass input that forces env to full scale without disturbing the
// state machine.
//
// state   | meaning
// IDLE    | amp held at 0, waiting for start
// ATTACK  | amp ramps up by attack_step until full scale
// DECAY   | amp ramps down by decay_step to the sustain level
// SUSTAIN | amp held at sustain level for sustain_time cycles (all-ones = forever)
// RELEASE | amp ramps down by release_step to 0
module ddfs_adsr #(
  parameter int SUS_W = 32
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DDFS_ADSR_BYPASS_EN
  input  logic bypass,
`endif
  ddfs_adsr_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [31:0] MAX = 32'h4000_0000;

  state_t           state, state_nxt;
  logic [31:0]      amp, amp_nxt;
  logic [SUS_W-1:0] cnt, cnt_nxt;
  logic [31:0]      sl;
  logic [32:0]      atk_sum;
  logic [32:0]      dec_diff;
  logic             hold_inf;
  logic             sus_done;
  logic             env_full;

  // Derived compare terms; 33-bit arithmetic keeps carries/borrows visible
  always_comb begin
    sl       = {(bus.sustain_level > 16'h4000) ? 16'h4000 : bus.sustain_level, 16'h0000};
    atk_sum  = {1'b0, amp} + {1'b0, bus.attack_step};
    dec_diff = {1'b0, amp} - {1'b0, bus.decay_step};
    hold_inf = &bus.sustain_time;
    sus_done = !hold_inf &&
               ((bus.sustain_time == '0) || (cnt == bus.sustain_time - SUS_W'(1)));
  end

  // Next-state / next-amplitude; start/stop overrides applied last so start wins
  always_comb begin
    state_nxt = state;
    amp_nxt   = amp;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        amp_nxt = '0;
        if (bus.start) state_nxt = ATTACK;
      end
      ATTACK: begin
        if ((bus.attack_step == '0) || (atk_sum >= {1'b0, MAX})) begin
          amp_nxt   = MAX;
          state_nxt = DECAY;
        end else begin
          amp_nxt = atk_sum[31:0];
        end
      end
      DECAY: begin
        if ((bus.decay_step == '0) || dec_diff[32] || (dec_diff[31:0] <= sl)) begin
          amp_nxt   = sl;
          cnt_nxt   = '0;
          state_nxt = SUSTAIN;
        end else begin
          amp_nxt = dec_diff[31:0];
        end
      end
      SUSTAIN: begin
        amp_nxt = sl;
        if (sus_done) state_nxt = RELEASE;
        else          cnt_nxt   = cnt + SUS_W'(1);
      end
      RELEASE: begin
        if ((bus.release_step == '0) || (amp <= bus.release_step)) begin
          amp_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          amp_nxt = amp - bus.release_step;
        end
      end
      default: begin
        state_nxt = IDLE;
        amp_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase

    // Retrigger and forced release both freeze amp for one edge (no click)
    if (state == ATTACK || state == DECAY || state == SUSTAIN || state == RELEASE) begin
      if (bus.start) begin
        state_nxt = ATTACK;
        amp_nxt   = amp;
      end else if (bus.stop && state != RELEASE) begin
        state_nxt = RELEASE;
        amp_nxt   = amp;
      end
    end
  end

`ifdef DDFS_ADSR_BYPASS_EN
  assign env_full = bypass;
`else
  assign env_full = 1'b0;
`endif

  // State, accumulator, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      amp         <= '0;
      cnt         <= '0;
      bus.env     <= '0;
      bus.idle    <= 1'b1;
      bus.state_o <= 3'd0;
    end else begin
      state       <= state_nxt;
      amp         <= amp_nxt;
      cnt         <= cnt_nxt;
      bus.env     <= env_full ? 16'sh4000 : amp_nxt[31:16];
      bus.idle    <= !env_full && (state_nxt == IDLE);
      bus.state_o <= state_nxt;
    end
  end

endmodule

// File: tb/tb_ddfs_adsr.sv
// tb_ddfs_adsr: directed test of the ADSR sequencer with hand-computed envelopes.
module tb_ddfs_adsr;

  logic clk;
  logic rst_n;
`ifdef DDFS_ADSR_BYPASS_EN
  logic bypass;
`endif
  int n_chk;
  int n_err;

  ddfs_adsr_if #(.SUS_W(32)) bus ();

  ddfs_adsr #(.SUS_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef DDFS_ADSR_BYPASS_EN
    .bypass(bypass),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic cfg_std();
    bus.attack_step   = 32'h0400_0000;
    bus.decay_step    = 32'h0100_0000;
    bus.sustain_level = 16'h2000;
    bus.sustain_time  = 32'd8;
    bus.release_step  = 32'h0080_0000;
  endtask

  initial begin
    bit saw_attack;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
`ifdef DDFS_ADSR_BYPASS_EN
    bypass = 1'b0;
`endif
    cfg_std();
    run(2);
    chk("rst_env", 32'(bus.env), 32'h0);
    chk("rst_idle", 32'(bus.idle), 32'h1);
    chk("rst_state", 32'(bus.state_o), 32'h0);
    rst_n = 1'b1;
    tick();

    // stop in IDLE is ignored
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("idle_stop_state", 32'(bus.state_o), 32'h0);
    chk("idle_stop_idle", 32'(bus.idle), 32'h1);

    // full envelope
    pulse_start();
    chk("start_state", 32'(bus.state_o), 32'h1);
    chk("start_env", 32'(bus.env), 32'h0);
    chk("start_idle", 32'(bus.idle), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("attack_env", 32'(bus.env), 32'(i * 16'h0400));
    end
    chk("attack_done_state", 32'(bus.state_o), 32'h2);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("decay_env", 32'(bus.env), 32'(16'h4000 - i * 16'h0100));
    end
    chk("decay_done_state", 32'(bus.state_o), 32'h3);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("sustain_env", 32'(bus.env), 32'h2000);
      chk("sustain_state", 32'(bus.state_o), (i == 8) ? 32'h4 : 32'h3);
    end
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk("release_env", 32'(bus.env), 32'(16'h2000 - i * 16'h0080));
    end
    chk("release_done_idle", 32'(bus.idle), 32'h1);
    chk("release_done_state", 32'(bus.state_o), 32'h0);

    // early stop during attack
    pulse_start();
    run(10);
    chk("early_pre_env", 32'(bus.env), 32'h2800);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("early_stop_state", 32'(bus.state_o), 32'h4);
    chk("early_stop_env", 32'(bus.env), 32'h2800);
    tick();
    chk("early_first_dec", 32'(bus.env), 32'h2780);
    saw_attack = 1'b0;
    for (int i = 0; i < 79; i++) begin
      tick();
      if (bus.state_o == 3'd1) saw_attack = 1'b1;
    end
    chk("early_no_attack", 32'(saw_attack), 32'h0);
    chk("early_idle", 32'(bus.idle), 32'h1);
    chk("early_env0", 32'(bus.env), 32'h0);

    // legato retrigger from release at 0x1000
    pulse_start();
    run(16 + 32 + 8 + 32);
    chk("retrig_pre_env", 32'(bus.env), 32'h1000);
    chk("retrig_pre_state", 32'(bus.state_o), 32'h4);
    pulse_start();
    chk("retrig_state", 32'(bus.state_o), 32'h1);
    chk("retrig_hold_env", 32'(bus.env), 32'h1000);
    tick();
    chk("retrig_next_env", 32'(bus.env), 32'h1400);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("both_state", 32'(bus.state_o), 32'h1);
    chk("both_env", 32'(bus.env), 32'h1400);
    tick();
    chk("both_next_env", 32'(bus.env), 32'h1800);

    // asynchronous reset mid-attack, checked before any clock edge
    rst_n = 1'b0;
    #1;
    chk("async_rst_env", 32'(bus.env), 32'h0);
    chk("async_rst_idle", 32'(bus.idle), 32'h1);
    chk("async_rst_state", 32'(bus.state_o), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(bus.state_o), 32'h0);

    // zero steps, infinite hold
    bus.attack_step  = '0;
    bus.decay_step   = '0;
    bus.release_step = '0;
    bus.sustain_time = '1;
    pulse_start();
    chk("zero_start_env", 32'(bus.env), 32'h0);
    tick();
    chk("zero_max_env", 32'(bus.env), 32'h4000);
    chk("zero_max_state", 32'(bus.state_o), 32'h2);
    tick();
    chk("zero_sl_env", 32'(bus.env), 32'h2000);
    run(40);
    chk("hold_state", 32'(bus.state_o), 32'h3);
    chk("hold_env", 32'(bus.env), 32'h2000);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("hold_stop_state", 32'(bus.state_o), 32'h4);
    chk("hold_stop_env", 32'(bus.env), 32'h2000);
    tick();
    chk("zero_rel_env", 32'(bus.env), 32'h0);
    chk("zero_rel_idle", 32'(bus.idle), 32'h1);

    // sustain level clamp and sustain_time = 0
    bus.sustain_level = 16'h7FFF;
    bus.sustain_time  = '0;
    pulse_start();
    run(2);
    chk("clamp_state", 32'(bus.state_o), 32'h3);
    chk("clamp_env", 32'(bus.env), 32'h4000);
    tick();
    chk("sus0_state", 32'(bus.state_o), 32'h4);
    tick();
    chk("sus0_idle", 32'(bus.idle), 32'h1);

`ifdef DDFS_ADSR_BYPASS_EN
    cfg_std();
    pulse_start();
    run(16 + 4);
    chk("byp_pre_env", 32'(bus.env), 32'h3C00);
    bypass = 1'b1;
    tick();
    chk("byp_env", 32'(bus.env), 32'h4000);
    chk("byp_idle", 32'(bus.idle), 32'h0);
    tick();
    bypass = 1'b0;
    tick();
    chk("byp_off_env", 32'(bus.env), 32'h3900);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ddfs_adsr.md
# ddfs_adsr

Envelope sequencer for the DDFS tone datapath. It generates the signed 16-bit `env` amplitude that scales the sine ROM output, using an attack/decay/sustain/release (ADSR) state machine. Software triggers it with start/stop pulses, and it runs one envelope per note. The block sits between the register file and the DDFS `env` input, one instance per DDFS channel.

## Interface
Parameters:
- `SUS_W`, 32, width of the sustain-duration counter and `sustain_time`.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset. Asynchronous, active-low.
- `start`  input  1  one-cycle pulse; begins or restarts a note.
- `stop`  input  1  one-cycle pulse; forces release.
- `attack_step`  input  32  amplitude added per cycle in ATTACK.
- `decay_step`  input  32  amplitude subtracted per cycle in DECAY.
- `sustain_level`  input  16  sustain amplitude in env units (Q2.14, 0x4000 = 1.0).
- `sustain_time`  input  SUS_W  sustain duration in cycles; all-ones = hold until `stop`.
- `release_step`  input  32  amplitude subtracted per cycle in RELEASE.
- `env`  output  16  signed envelope to DDFS, Q2.14, range 0x0000..0x4000.
- `idle`  output  1  high when state is IDLE.
- `state_o`  output  3  current state code, for debug and the register readback.

## Operation
- Amplitude accumulator `amp`:
  - 32-bit unsigned; MAX = 0x4000_0000; `env` = `amp[31:16]`.
  - `amp` is never above MAX.
- Sustain target: SL = {min(`sustain_level`, 16'h4000), 16'h0000}.
- States and codes: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Codes 5..7 are illegal and return to IDLE with `amp`=0.
- IDLE: `amp` held at 0. `start` → ATTACK.
- ATTACK: if `attack_step`=0 or `amp`+`attack_step` ≥ MAX, then `amp`=MAX and → DECAY. Otherwise `amp` += `attack_step`.
- DECAY:
  - If `decay_step`=0 or `amp` − `decay_step` ≤ SL, then `amp`=SL, clear the sustain counter, → SUSTAIN.
  - Otherwise `amp` −= `decay_step`.
  - The compare uses a 33-bit difference, so no underflow wrap.
- SUSTAIN: `amp` held at SL.
  - Counter increments each cycle.
  - When counter = `sustain_time`−1 → RELEASE, unless `sustain_time` is all-ones.
  - `sustain_time`=0 → RELEASE on the first SUSTAIN cycle.
- RELEASE: if `release_step`=0 or `amp` ≤ `release_step`, then `amp`=0 and → IDLE. Otherwise `amp` −= `release_step`.
- `stop` in ATTACK, DECAY or SUSTAIN → RELEASE next cycle. Releasing starts from the current `amp`, with no jump.
- `stop` in IDLE or RELEASE is ignored.
- `start` in any non-IDLE state → ATTACK from the current `amp` (legato retrigger, no click).
- `start` and `stop` in the same cycle: `start` wins.
- Step inputs are sampled every cycle. Changing them mid-note takes effect on the next update.

## Timing
- Reset: state=IDLE, `amp`=0, sustain counter=0, `env`=0x0000, `idle`=1, `state_o`=0. Reset is effective immediately, also mid-note.
- `env`, `idle` and `state_o` are registered; there is no combinational path from inputs.
- `start` sampled high at edge k:
  - After edge k: state=ATTACK, `amp` unchanged.
  - First increment at edge k+1.
- Every state transition takes exactly one edge. The saturating cycle both clamps `amp` and changes state.
- `stop` sampled at edge k: state=RELEASE after edge k; first decrement at edge k+1.
- Attack length with step S: ceil(MAX/S) update cycles.

## Configuration
- Macro `DDFS_ADSR_BYPASS_EN`:
  - Defined: adds input port `bypass` (1 bit). While `bypass`=1, `env` = 0x4000 and `idle`=0, but the state machine keeps running unaffected. When `bypass` returns to 0, `env` follows `amp` again.
  - Not defined: no `bypass` port; `env` always follows `amp`.

## Test plan
- Reset: assert `rst_n`=0 mid-ATTACK → `env`=0, `idle`=1, `state_o`=0 immediately, without waiting for a clock edge.
- Full envelope:
  - Stimulus: `attack_step`=0x0400_0000, `decay_step`=0x0100_0000, `sustain_level`=0x2000, `sustain_time`=8, `release_step`=0x0080_0000.
  - Required response: `env` ramps 0x0400, 0x0800 … 0x4000 in 16 cycles; decays to 0x2000 in 32 cycles; holds 8 cycles; releases to 0 in 64 cycles; `idle`=1.
- Early stop: same config, `stop` at `env`=0x2800 during ATTACK → RELEASE next cycle; `env` falls 0x2800, 0x2780 …; ATTACK is never re-entered.
- Retrigger: `start` during RELEASE at `env`=0x1000 → ATTACK continues from 0x1000 (next value 0x1400); `start`+`stop` in the same cycle → ATTACK.
- Zero steps and infinite hold:
  - All steps 0, `sustain_time`=all-ones → MAX after 1 update cycle, SL after 1 more, then hold indefinitely.
  - `stop` → `env`=0 one cycle after entering RELEASE.
- Clamp: `sustain_level`=0x7FFF → SUSTAIN at `env`=0x4000. With `DDFS_ADSR_BYPASS_EN` defined and `bypass`=1 during DECAY → `env`=0x4000; release `bypass` → `env` equals the current decay value.
